adam_rst_seq: RTL and testbench



---
 rtl/adam_rst_seq.sv | 153 +++++++++++++++
 tb/tb_adam_rst_seq.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/adam_rst_seq.sv
// Reset sequencer: holds all domain resets after board reset, releases them
// one by one in index order, and services software reset requests by first
// pausing every domain (req/ack with timeout) before re-entering the hold.
module adam_rst_seq #(
   parameter int NO_DOMAINS     = 2,
   parameter int HOLD_CYCLES    = 16,
   parameter int STAGGER_CYCLES = 4,
   parameter int TIMEOUT_CYCLES = 64,
   parameter int CNT_WIDTH      = $clog2(
      (HOLD_CYCLES > STAGGER_CYCLES)
         ? ((HOLD_CYCLES > TIMEOUT_CYCLES) ? HOLD_CYCLES : TIMEOUT_CYCLES)
         : ((STAGGER_CYCLES > TIMEOUT_CYCLES) ? STAGGER_CYCLES : TIMEOUT_CYCLES)) + 1
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  soft_rst_req_i,
   output logic                  soft_rst_ack_o,
   output logic [NO_DOMAINS-1:0] pause_req_o,
   input  logic [NO_DOMAINS-1:0] pause_ack_i,
   output logic [NO_DOMAINS-1:0] rst_o,
   output logic                  busy_o,
   output logic                  timeout_o
);

   if (NO_DOMAINS < 1 || HOLD_CYCLES < 1 || STAGGER_CYCLES < 1 ||
       TIMEOUT_CYCLES < 1 || CNT_WIDTH < 1) begin : g_param_chk
      $error("adam_rst_seq: every parameter must be >= 1");
   end

   // idx must be able to hold NO_DOMAINS (value after the last release)
   localparam int IDX_W = (NO_DOMAINS < 2) ? 1 : $clog2(NO_DOMAINS + 1);

   localparam logic [CNT_WIDTH-1:0] HOLD_LAST    = CNT_WIDTH'(HOLD_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] STAGGER_LAST = CNT_WIDTH'(STAGGER_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
   localparam logic [IDX_W-1:0]     IDX_LAST     = IDX_W'(NO_DOMAINS - 1);

   typedef enum logic [1:0] {
      S_HOLD    = 2'd0,
      S_RELEASE = 2'd1,
      S_RUN     = 2'd2,
      S_PAUSE   = 2'd3
   } state_t;

   state_t                  state_q, state_d;
   logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [NO_DOMAINS-1:0]   rst_q, rst_d;
   logic [NO_DOMAINS-1:0]   pause_req_q, pause_req_d;
   logic                    ack_q, ack_d;
   logic                    busy_q, busy_d;
   logic                    timeout_q, timeout_d;
   logic                    all_ack;

   assign all_ack = &pause_ack_i;

   // State register: every output comes straight from a flop
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q     <= S_HOLD;
         cnt_q       <= '0;
         idx_q       <= '0;
         rst_q       <= '1;
         pause_req_q <= '0;
         ack_q       <= 1'b0;
         busy_q      <= 1'b1;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         rst_q       <= rst_d;
         pause_req_q <= pause_req_d;
         ack_q       <= ack_d;
         busy_q      <= busy_d;
         timeout_q   <= timeout_d;
      end
   end

   // Next-state and next-output logic; the ack pulse defaults low so it lasts one cycle
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      rst_d       = rst_q;
      pause_req_d = pause_req_q;
      ack_d       = 1'b0;
      busy_d      = busy_q;
      timeout_d   = timeout_q;

      unique case (state_q)
         S_HOLD: begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
            if (cnt_q == HOLD_LAST) begin
               rst_d[0] = 1'b0;
               cnt_d    = '0;
               idx_d    = IDX_W'(1);
               if (NO_DOMAINS == 1) begin
                  state_d = S_RUN;
                  busy_d  = 1'b0;
               end else begin
                  state_d = S_RELEASE;
               end
            end
         end
         S_RELEASE: begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
            if (cnt_q == STAGGER_LAST) begin
               for (int k = 0; k < NO_DOMAINS; k++) begin
                  if (idx_q == IDX_W'(k)) rst_d[k] = 1'b0;
               end
               cnt_d = '0;
               idx_d = idx_q + IDX_W'(1);
               if (idx_q == IDX_LAST) begin
                  state_d = S_RUN;
                  busy_d  = 1'b0;
               end
            end
         end
         S_RUN: begin
            if (soft_rst_req_i) begin
               state_d     = S_PAUSE;
               pause_req_d = '1;
               cnt_d       = '0;
               busy_d      = 1'b1;
            end
         end
         S_PAUSE: begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
            if (all_ack || cnt_q == TIMEOUT_LAST) begin
               state_d     = S_HOLD;
               rst_d       = '1;
               pause_req_d = '0;
               ack_d       = 1'b1;
               cnt_d       = '0;
               idx_d       = '0;
               // A full ack on the timeout edge counts as a clean pause
               if (!all_ack) timeout_d = 1'b1;
            end
         end
         default: begin
            state_d = S_HOLD;
         end
      endcase
   end

   assign rst_o          = rst_q;
   assign pause_req_o    = pause_req_q;
   assign soft_rst_ack_o = ack_q;
   assign busy_o         = busy_q;
   assign timeout_o      = timeout_q;

endmodule

// File: tb/tb_adam_rst_seq.sv
// Directed bench for adam_rst_seq: expectations are queued as stimulus is
// driven and compared one edge later against two instances (default
// parameters, and a four-domain fast-release configuration).
module tb_adam_rst_seq;

   localparam int H = 16;
   localparam int S = 4;
   localparam int T = 64;

   typedef struct packed {
      logic       sel;   // 0: default instance, 1: four-domain instance
      logic [3:0] rst;
      logic [3:0] preq;
      logic       ack;
      logic       busy;
      logic       tmo;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req_a = 1'b0;
   logic [1:0] pack_a = 2'b00;
   logic       sack_a;
   logic [1:0] preq_a;
   logic [1:0] rst_a;
   logic       busy_a;
   logic       tmo_a;

   logic       req_b = 1'b0;
   logic [3:0] pack_b = 4'h0;
   logic       sack_b;
   logic [3:0] preq_b;
   logic [3:0] rst_b;
   logic       busy_b;
   logic       tmo_b;

   vec_t  exp_q[$];
   string tag_q[$];
   int    vectors = 0;
   int    miscompares = 0;

   always #5 clk = ~clk;

   adam_rst_seq dut_a (
      .clk_i          (clk),
      .rst_n_i        (rst_n),
      .soft_rst_req_i (req_a),
      .soft_rst_ack_o (sack_a),
      .pause_req_o    (preq_a),
      .pause_ack_i    (pack_a),
      .rst_o          (rst_a),
      .busy_o         (busy_a),
      .timeout_o      (tmo_a)
   );

   adam_rst_seq #(
      .NO_DOMAINS     (4),
      .HOLD_CYCLES    (1),
      .STAGGER_CYCLES (1),
      .TIMEOUT_CYCLES (8)
   ) dut_b (
      .clk_i          (clk),
      .rst_n_i        (rst_n),
      .soft_rst_req_i (req_b),
      .soft_rst_ack_o (sack_b),
      .pause_req_o    (preq_b),
      .pause_ack_i    (pack_b),
      .rst_o          (rst_b),
      .busy_o         (busy_b),
      .timeout_o      (tmo_b)
   );

   task automatic push_a(input string tag, input logic [1:0] r, input logic [1:0] p,
                         input logic ack, input logic busy, input logic tmo);
      exp_q.push_back('{sel: 1'b0, rst: {2'b00, r}, preq: {2'b00, p},
                        ack: ack, busy: busy, tmo: tmo});
      tag_q.push_back(tag);
   endtask

   task automatic push_b(input string tag, input logic [3:0] r, input logic busy);
      exp_q.push_back('{sel: 1'b1, rst: r, preq: 4'h0, ack: 1'b0, busy: busy, tmo: 1'b0});
      tag_q.push_back(tag);
   endtask

   // Advance one edge, then compare everything queued for it
   task automatic tick();
      vec_t  e;
      vec_t  o;
      string t;
      @(posedge clk);
      #1;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         if (e.sel == 1'b0)
            o = '{sel: 1'b0, rst: {2'b00, rst_a}, preq: {2'b00, preq_a},
                  ack: sack_a, busy: busy_a, tmo: tmo_a};
         else
            o = '{sel: 1'b1, rst: rst_b, preq: preq_b,
                  ack: sack_b, busy: busy_b, tmo: tmo_b};
         vectors++;
         assert (o === e) else begin
            miscompares++;
            $error("FAIL %s: observed rst=%h preq=%h ack=%b busy=%b tmo=%b, expected rst=%h preq=%h ack=%b busy=%b tmo=%b",
                   t, o.rst, o.preq, o.ack, o.busy, o.tmo, e.rst, e.preq, e.ack, e.busy, e.tmo);
         end
      end
   endtask

   // Hold/release sequence of the default instance, j = edges since entering HOLD
   task automatic check_release(input string tag, input logic tmo);
      for (int j = 1; j <= H + S; j++) begin
         push_a($sformatf("%s_e%0d", tag, j),
                {logic'(j < H + S), logic'(j < H)}, 2'b00, 1'b0, logic'(j < H + S), tmo);
         tick();
      end
   endtask

   task automatic check_pause(input string tag, input int n, input logic tmo);
      for (int k = 1; k <= n; k++) begin
         push_a($sformatf("%s_c%0d", tag, k), 2'b00, 2'b11, 1'b0, 1'b1, tmo);
         tick();
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, observed timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Board reset held for three edges
      for (int i = 0; i < 3; i++) begin
         push_a("reset_a", 2'b11, 2'b00, 1'b0, 1'b1, 1'b0);
         push_b("reset_b", 4'hF, 1'b1);
         tick();
      end

      // Power-on release: both instances checked against the release timing
      rst_n = 1'b1;
      for (int e = 1; e <= H + S; e++) begin
         push_a($sformatf("por_a_e%0d", e),
                {logic'(e < H + S), logic'(e < H)}, 2'b00, 1'b0, logic'(e < H + S), 1'b0);
         if (e <= 5)
            push_b($sformatf("por_b_e%0d", e),
                   {logic'(e < 4), logic'(e < 3), logic'(e < 2), logic'(e < 1)},
                   logic'(e < 4));
         tick();
      end
      push_a("run_idle", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
      tick();

      // Soft reset with full ack three cycles after the pause request
      req_a = 1'b1;
      push_a("soft_enter", 2'b00, 2'b11, 1'b0, 1'b1, 1'b0);
      tick();
      req_a = 1'b0;
      check_pause("soft_wait", 2, 1'b0);
      pack_a = 2'b11;
      push_a("soft_ack", 2'b11, 2'b00, 1'b1, 1'b1, 1'b0);
      tick();
      pack_a = 2'b00;
      check_release("soft_rel", 1'b0);

      // Soft reset with a partial ack: only the timeout can end the pause
      pack_a = 2'b01;
      req_a  = 1'b1;
      push_a("to_enter", 2'b00, 2'b11, 1'b0, 1'b1, 1'b0);
      tick();
      req_a = 1'b0;
      check_pause("to_wait", T - 1, 1'b0);
      push_a("to_exit", 2'b11, 2'b00, 1'b1, 1'b1, 1'b1);
      tick();
      pack_a = 2'b00;
      check_release("to_rel", 1'b1);

      // A later clean soft reset leaves the sticky timeout flag set
      req_a = 1'b1;
      push_a("sticky_enter", 2'b00, 2'b11, 1'b0, 1'b1, 1'b1);
      tick();
      req_a  = 1'b0;
      pack_a = 2'b11;
      push_a("sticky_ack", 2'b11, 2'b00, 1'b1, 1'b1, 1'b1);
      tick();
      pack_a = 2'b00;
      check_release("sticky_rel", 1'b1);

      // Board reset clears the timeout flag
      rst_n = 1'b0;
      push_a("tmo_clear", 2'b11, 2'b00, 1'b0, 1'b1, 1'b0);
      tick();
      rst_n = 1'b1;
      check_release("clr_rel", 1'b0);

      // Board reset during PAUSE with the request held high
      req_a = 1'b1;
      push_a("held_enter", 2'b00, 2'b11, 1'b0, 1'b1, 1'b0);
      tick();
      check_pause("held_wait", 2, 1'b0);
      rst_n = 1'b0;
      push_a("held_rst", 2'b11, 2'b00, 1'b0, 1'b1, 1'b0);
      tick();
      rst_n = 1'b1;
      // Request stays high through HOLD and RELEASE without effect
      check_release("held_rel", 1'b0);
      push_a("held_reenter", 2'b00, 2'b11, 1'b0, 1'b1, 1'b0);
      tick();
      req_a = 1'b0;

      // Full ack arriving on the timeout edge: ack wins, flag stays clear
      check_pause("tie_wait", T - 1, 1'b0);
      pack_a = 2'b11;
      push_a("tie_exit", 2'b11, 2'b00, 1'b1, 1'b1, 1'b0);
      tick();
      pack_a = 2'b00;
      push_a("tie_after", 2'b11, 2'b00, 1'b0, 1'b1, 1'b0);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
